// File: rtl/pio_bank_pkg.sv
// Shared constants and elaboration-time helpers for the PIO bank.
// Register offsets within a port's four-word window, plus width helpers.
package pio_bank_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_DIR  = 2'd1;
    localparam logic [1:0] REG_MASK = 2'd2;
    localparam logic [1:0] REG_EDGE = 2'd3;

    function automatic int clog2i(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    function automatic int addr_w(input int num_ports);
        return clog2i(num_ports) + 2;
    endfunction

    // Width needed to count 0..cyc-1, never less than one bit.
    function automatic int presc_w(input int cyc);
        return (cyc <= 2) ? 1 : clog2i(cyc);
    endfunction

endpackage

// File: rtl/pio_debounce.sv
// Two-flop synchroniser plus two-sample debounce for one port.
// The debounced bit follows the synchronised bit once two consecutive tick samples agree.
module pio_debounce #(
    parameter int DATA_W = 32,
    parameter bit BYPASS = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] sync_1;
    logic [DATA_W-1:0] sync_2;
    logic [DATA_W-1:0] samp;
    logic [DATA_W-1:0] deb;
    logic [DATA_W-1:0] differ;

    assign differ = samp ^ sync_2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= '0;
            sync_2 <= '0;
            samp   <= '0;
            deb    <= '0;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            if (tick) begin
                samp <= sync_2;
                deb  <= (deb & differ) | (sync_2 & ~differ);
            end
        end
    end

    assign dout = BYPASS ? sync_2 : deb;

endmodule

// File: rtl/pio_bank_avmm.sv
// Avalon-MM bank of NUM_PORTS bidirectional PIO ports with debounced inputs,
// rising-edge capture and a maskable level interrupt.
module pio_bank_avmm
    import pio_bank_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NUM_PORTS    = 4,
    parameter int DEBOUNCE_CYC = 1000,
    parameter int RESET_OUT    = 0,
    localparam int ADDR_W      = addr_w(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [ADDR_W-1:0]           avs_address,
    input  logic                        avs_read,
    input  logic                        avs_write,
    input  logic [31:0]                 avs_writedata,
    output logic [31:0]                 avs_readdata,
    output logic                        avs_readdatavalid,
    output logic                        irq,
    input  logic [NUM_PORTS*DATA_W-1:0] pio_in,
    output logic [NUM_PORTS*DATA_W-1:0] pio_out,
    output logic [NUM_PORTS*DATA_W-1:0] pio_oe
);

    localparam logic [DATA_W-1:0] OUT_RST = {DATA_W{RESET_OUT != 0}};

    logic [NUM_PORTS-1:0][DATA_W-1:0] out_r, dir_r, mask_r, edge_r, deb, deb_q;
    logic [NUM_PORTS-1:0]             wsel;
    logic [31:0]                      a_port;
    logic [1:0]                       a_reg;
    logic                             a_hit;
    logic [31:0]                      rd_val;
    logic [DATA_W-1:0]                wd;
    logic                             tick;

    generate
        if (DEBOUNCE_CYC == 0) begin : g_no_presc
            assign tick = 1'b1;
        end else begin : g_presc
            localparam int PW = presc_w(DEBOUNCE_CYC);
            localparam logic [PW-1:0] LAST = PW'(DEBOUNCE_CYC - 1);
            logic [PW-1:0] cnt;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)            cnt <= '0;
                else if (cnt == LAST) cnt <= '0;
                else                  cnt <= cnt + 1'b1;
            end
            assign tick = (cnt == LAST);
        end

        for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
            pio_debounce #(
                .DATA_W (DATA_W),
                .BYPASS (DEBOUNCE_CYC == 0)
            ) u_deb (
                .clk   (clk),
                .reset (reset),
                .tick  (tick),
                .din   (pio_in[p*DATA_W +: DATA_W]),
                .dout  (deb[p])
            );
        end
    endgenerate

    // Upper address bits select the port; anything past the last port is a hole.
    assign a_port = 32'(avs_address) >> 2;
    assign a_reg  = avs_address[1:0];
    assign a_hit  = (a_port < 32'(NUM_PORTS));
    assign wd     = avs_writedata[DATA_W-1:0];

    always_comb begin
        rd_val = '0;
        wsel   = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (a_hit && a_port == 32'(p)) begin
                wsel[p] = avs_write;
                case (a_reg)
                    REG_DATA: rd_val = 32'((deb[p] & ~dir_r[p]) | (out_r[p] & dir_r[p]));
                    REG_DIR:  rd_val = 32'(dir_r[p]);
                    REG_MASK: rd_val = 32'(mask_r[p]);
                    REG_EDGE: rd_val = 32'(edge_r[p]);
                    default:  rd_val = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r             <= {NUM_PORTS{OUT_RST}};
            dir_r             <= '0;
            mask_r            <= '0;
            edge_r            <= '0;
            deb_q             <= '0;
            irq               <= 1'b0;
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= avs_read;
            if (avs_read) avs_readdata <= rd_val;
            irq   <= |(edge_r & mask_r);
            deb_q <= deb;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (wsel[p] && a_reg == REG_DATA) out_r[p]  <= wd;
                if (wsel[p] && a_reg == REG_DIR)  dir_r[p]  <= wd;
                if (wsel[p] && a_reg == REG_MASK) mask_r[p] <= wd;
                // A rise arriving in the same cycle as a clear survives it.
                edge_r[p] <= (edge_r[p] & ~((wsel[p] && a_reg == REG_EDGE) ? wd : '0))
                           | (deb[p] & ~deb_q[p] & ~dir_r[p]);
            end
        end
    end

    assign pio_out = out_r;
    assign pio_oe  = dir_r;

endmodule

// File: tb/tb_pio_bank_avmm.sv
// Bench for pio_bank_avmm: a 4x32 bank with short debounce and a 3x8 bank without.
// Read results are predicted at issue time and compared when readdatavalid pulses.
module tb_pio_bank_avmm;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [3:0]   a_addr, b_addr;
    logic         a_rd, a_wr, b_rd, b_wr;
    logic [31:0]  a_wd, b_wd, a_rdata, b_rdata;
    logic         a_rdv, b_rdv, a_irq, b_irq;
    logic [127:0] a_in, a_out, a_oe;
    logic [23:0]  b_in, b_out, b_oe;

    logic [31:0] a_exp_q[$];
    logic [31:0] b_exp_q[$];
    string       a_tag_q[$];
    string       b_tag_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    pio_bank_avmm #(.DATA_W(32), .NUM_PORTS(4), .DEBOUNCE_CYC(4), .RESET_OUT(0)) dut_a (
        .clk(clk), .reset(reset), .avs_address(a_addr), .avs_read(a_rd), .avs_write(a_wr),
        .avs_writedata(a_wd), .avs_readdata(a_rdata), .avs_readdatavalid(a_rdv), .irq(a_irq),
        .pio_in(a_in), .pio_out(a_out), .pio_oe(a_oe)
    );

    pio_bank_avmm #(.DATA_W(8), .NUM_PORTS(3), .DEBOUNCE_CYC(0), .RESET_OUT(1)) dut_b (
        .clk(clk), .reset(reset), .avs_address(b_addr), .avs_read(b_rd), .avs_write(b_wr),
        .avs_writedata(b_wd), .avs_readdata(b_rdata), .avs_readdatavalid(b_rdv), .irq(b_irq),
        .pio_in(b_in), .pio_out(b_out), .pio_oe(b_oe)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Bus tasks start and end on a falling edge.
    task automatic a_write(input logic [3:0] ad, input logic [31:0] d);
        a_addr = ad; a_wd = d; a_wr = 1'b1;
        @(negedge clk);
        a_wr = 1'b0;
    endtask

    task automatic a_read(input logic [3:0] ad, input logic [31:0] e, input string tag);
        a_exp_q.push_back(e); a_tag_q.push_back(tag);
        a_addr = ad; a_rd = 1'b1;
        @(negedge clk);
        a_rd = 1'b0;
    endtask

    task automatic a_rw(input logic [3:0] ad, input logic [31:0] d, input logic [31:0] e, input string tag);
        a_exp_q.push_back(e); a_tag_q.push_back(tag);
        a_addr = ad; a_wd = d; a_rd = 1'b1; a_wr = 1'b1;
        @(negedge clk);
        a_rd = 1'b0; a_wr = 1'b0;
    endtask

    task automatic b_write(input logic [3:0] ad, input logic [31:0] d);
        b_addr = ad; b_wd = d; b_wr = 1'b1;
        @(negedge clk);
        b_wr = 1'b0;
    endtask

    task automatic b_read(input logic [3:0] ad, input logic [31:0] e, input string tag);
        b_exp_q.push_back(e); b_tag_q.push_back(tag);
        b_addr = ad; b_rd = 1'b1;
        @(negedge clk);
        b_rd = 1'b0;
    endtask

    // Leaves the bench on the falling edge just before a prescaler tick edge.
    task automatic wait_tick();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (dut_a.tick) break;
        end
        check("tick_seen", {31'b0, dut_a.tick}, 32'd1);
    endtask

    always @(negedge clk) begin
        if (a_rdv) begin
            if (a_exp_q.size() == 0) check("a_rdv_extra", {31'b0, a_rdv}, 32'd0);
            else check(a_tag_q.pop_front(), a_rdata, a_exp_q.pop_front());
        end
        if (b_rdv) begin
            if (b_exp_q.size() == 0) check("b_rdv_extra", {31'b0, b_rdv}, 32'd0);
            else check(b_tag_q.pop_front(), b_rdata, b_exp_q.pop_front());
        end
    end

    initial begin
        reset = 1'b1;
        a_addr = '0; a_rd = 1'b0; a_wr = 1'b0; a_wd = '0; a_in = '0;
        b_addr = '0; b_rd = 1'b0; b_wr = 1'b0; b_wd = '0; b_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int p = 0; p < 4; p++) begin
            check("rst_oe", a_oe[p*32 +: 32], 32'h0);
            check("rst_out", a_out[p*32 +: 32], 32'h0);
        end
        check("rst_irq", {31'b0, a_irq}, 32'd0);
        check("b_rst_out", {8'h0, b_out}, 32'h00FF_FFFF);
        for (int i = 0; i < 16; i++) a_read(4'(i), 32'h0, "rst_rd");

        // Port 0 split: low half outputs, high half inputs.
        a_write(4'd1, 32'h0000_FFFF);
        a_write(4'd0, 32'hA5A5_A5A5);
        a_in[31:0] = 32'h1234_0000;
        repeat (20) @(negedge clk);
        check("out0", a_out[31:0], 32'hA5A5_A5A5);
        check("oe0", a_oe[31:0], 32'h0000_FFFF);
        a_read(4'd0, 32'h1234_A5A5, "data0_mixed");
        a_read(4'd1, 32'h0000_FFFF, "dir0");

        a_rw(4'd9, 32'h55, 32'h0, "rw_prewrite");
        a_read(4'd9, 32'h55, "rw_after");
        a_write(4'd9, 32'h0);

        // 3-cycle glitch can be sampled by at most one tick.
        a_in[35] = 1'b1;
        repeat (3) @(negedge clk);
        a_in[35] = 1'b0;
        repeat (20) @(negedge clk);
        a_read(4'd4, 32'h0, "glitch_data1");
        a_read(4'd7, 32'h0, "glitch_edge1");

        a_in[35] = 1'b1;
        repeat (10) @(negedge clk);
        a_read(4'd4, 32'h8, "hold_data1");
        a_read(4'd7, 32'h8, "hold_edge1");

        a_write(4'd6, 32'h8);
        check("irq_pre_mask", {31'b0, a_irq}, 32'd0);
        @(negedge clk);
        check("irq_set", {31'b0, a_irq}, 32'd1);

        a_write(4'd5, 32'h8);
        a_read(4'd7, 32'h8, "edge_kept_dir");
        a_write(4'd5, 32'h0);

        a_write(4'd7, 32'h8);
        check("irq_pre_clear", {31'b0, a_irq}, 32'd1);
        @(negedge clk);
        check("irq_cleared", {31'b0, a_irq}, 32'd0);
        a_read(4'd7, 32'h0, "edge_cleared");

        // Fresh rise landing in the same cycle as the clear.
        a_in[35] = 1'b0;
        repeat (24) @(negedge clk);
        wait_tick();
        @(negedge clk);
        a_in[35] = 1'b1;
        wait_tick();
        @(negedge clk);
        wait_tick();
        @(negedge clk);
        a_write(4'd7, 32'h8);
        a_read(4'd7, 32'h8, "set_beats_clear");
        check("irq_reset_again", {31'b0, a_irq}, 32'd1);

        // Narrow, three-port bank without debounce.
        b_write(4'd1, 32'hFFFF_FFFF);
        b_write(4'd0, 32'hFFFF_FF12);
        b_read(4'd0, 32'h12, "b_data0_zext");
        b_read(4'd1, 32'hFF, "b_dir0_zext");
        b_read(4'd12, 32'h0, "b_oor_read");
        b_write(4'd13, 32'hFFFF_FFFF);
        b_write(4'd12, 32'h0);
        b_read(4'd9, 32'h0, "b_dir2_untouched");
        b_read(4'd5, 32'h0, "b_dir1_untouched");
        check("b_oe_after_oor", {8'h0, b_oe}, 32'h0000_00FF);
        check("b_out_after_oor", {8'h0, b_out}, 32'h00FF_FF12);
        b_in[15:8] = 8'h5A;
        repeat (2) @(negedge clk);
        b_read(4'd4, 32'h5A, "b_sync_latency2");

        // Reset lands after the read strobe was captured, before it is seen.
        a_addr = 4'd1; a_rd = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        a_rd = 1'b0;
        @(negedge clk);
        check("rst_drop_rdv", {31'b0, a_rdv}, 32'd0);
        check("rst2_oe0", a_oe[31:0], 32'h0);
        check("rst2_out0", a_out[31:0], 32'h0);
        check("rst2_irq", {31'b0, a_irq}, 32'd0);
        check("b_rst2_out", {8'h0, b_out}, 32'h00FF_FFFF);
        reset = 1'b0;
        @(negedge clk);
        a_read(4'd1, 32'h0, "rst2_dir0");
        a_read(4'd6, 32'h0, "rst2_mask1");
        a_read(4'd7, 32'h0, "rst2_edge1");
        repeat (3) @(negedge clk);

        check("a_q_drained", 32'(a_exp_q.size()), 32'd0);
        check("b_q_drained", 32'(b_exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
